// File: rtl/hvsync_pkg.sv
// Shared timing constants and helpers for the raster timing generator.
// Holds the default 256x240 CHIP-8 timing, the 9-bit beam-position type and
// the formulas that turn porch/sync widths into sync window edges and wrap points.
package hvsync_pkg;

    typedef logic [8:0] pos_t;

    // Largest value a 9-bit position counter can hold.
    localparam int unsigned PosMax = 511;

    localparam int unsigned HDisplayDef = 256;
    localparam int unsigned HBackDef    = 23;
    localparam int unsigned HFrontDef   = 7;
    localparam int unsigned HSyncDef    = 23;
    localparam int unsigned VDisplayDef = 240;
    localparam int unsigned VTopDef     = 5;
    localparam int unsigned VBottomDef  = 14;
    localparam int unsigned VSyncDef    = 3;

    // Sync starts right after the visible area plus the front porch.
    function automatic int unsigned sync_start(input int unsigned display,
                                               input int unsigned front);
        return display + front;
    endfunction

    function automatic int unsigned sync_end(input int unsigned start,
                                             input int unsigned width);
        return start + width - 1;
    endfunction

    function automatic int unsigned axis_max(input int unsigned display,
                                             input int unsigned back,
                                             input int unsigned front,
                                             input int unsigned width);
        return display + back + front + width - 1;
    endfunction

endpackage

// File: rtl/hvsync_timing_gen_if.sv
// Video timing bundle between the generator (master) and its consumers (slave).
// Signals: hsync, vsync (registered sync pulses), display_on (visible area),
// hpos, vpos (beam position), frame_start (only with HVSYNC_FRAME_STROBE_EN).
interface hvsync_timing_gen_if;
    import hvsync_pkg::*;

    logic hsync;
    logic vsync;
    logic display_on;
    pos_t hpos;
    pos_t vpos;
`ifdef HVSYNC_FRAME_STROBE_EN
    logic frame_start;
`endif

    modport master (
        output hsync,
        output vsync,
        output display_on,
        output hpos,
        output vpos
`ifdef HVSYNC_FRAME_STROBE_EN
        ,
        output frame_start
`endif
    );

    modport slave (
        input hsync,
        input vsync,
        input display_on,
        input hpos,
        input vpos
`ifdef HVSYNC_FRAME_STROBE_EN
        ,
        input frame_start
`endif
    );

endinterface

// File: rtl/hvsync_axis_counter.sv
// One raster axis: a 9-bit counter that steps when en_i is high and wraps
// from MAX back to 0.
// Ports: clk, reset (async, active-high), en_i (step enable),
// count_o (current position), wrap_o (high on the step that wraps to 0).
module hvsync_axis_counter
    import hvsync_pkg::*;
#(
    parameter int unsigned MAX = 308
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output pos_t count_o,
    output logic wrap_o
);

    if (MAX > PosMax) begin : g_max_check
        $error("hvsync_axis_counter: MAX %0d does not fit a 9-bit counter", MAX);
    end

    pos_t count_q;
    pos_t count_d;

    assign wrap_o  = en_i && (count_q == pos_t'(MAX));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hvsync_timing_gen.sv
// Free-running raster timing generator for the CHIP-8 video path.
// Ports: clk (pixel clock), reset (async, active-high), vid (master side of
// hvsync_timing_gen_if: hsync, vsync, display_on, hpos, vpos).
// Optional: define HVSYNC_FRAME_STROBE_EN to add vid.frame_start, a one-clock
// pulse coincident with hpos==0 && vpos==0.
module hvsync_timing_gen
    import hvsync_pkg::*;
#(
    parameter int unsigned H_DISPLAY = HDisplayDef,
    parameter int unsigned H_BACK    = HBackDef,
    parameter int unsigned H_FRONT   = HFrontDef,
    parameter int unsigned H_SYNC    = HSyncDef,
    parameter int unsigned V_DISPLAY = VDisplayDef,
    parameter int unsigned V_TOP     = VTopDef,
    parameter int unsigned V_BOTTOM  = VBottomDef,
    parameter int unsigned V_SYNC    = VSyncDef
) (
    input  logic                   clk,
    input  logic                   reset,
    hvsync_timing_gen_if.master    vid
);

    localparam int unsigned H_SYNC_START = sync_start(H_DISPLAY, H_FRONT);
    localparam int unsigned H_SYNC_END   = sync_end(H_SYNC_START, H_SYNC);
    localparam int unsigned H_MAX        = axis_max(H_DISPLAY, H_BACK, H_FRONT, H_SYNC);
    localparam int unsigned V_SYNC_START = sync_start(V_DISPLAY, V_BOTTOM);
    localparam int unsigned V_SYNC_END   = sync_end(V_SYNC_START, V_SYNC);
    localparam int unsigned V_MAX        = axis_max(V_DISPLAY, V_TOP, V_BOTTOM, V_SYNC);

    pos_t hpos;
    pos_t vpos;
    logic h_wrap;
    logic v_wrap;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;

    hvsync_axis_counter #(
        .MAX (H_MAX)
    ) u_h_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .count_o (hpos),
        .wrap_o  (h_wrap)
    );

    // Vertical axis only steps on the edge where the line wraps.
    hvsync_axis_counter #(
        .MAX (V_MAX)
    ) u_v_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (h_wrap),
        .count_o (vpos),
        .wrap_o  (v_wrap)
    );

    // Decoded from the pre-edge position, so the sync pulses lag the counters by one clock.
    always_comb begin
        hsync_d = (hpos >= pos_t'(H_SYNC_START)) && (hpos <= pos_t'(H_SYNC_END));
        vsync_d = (vpos >= pos_t'(V_SYNC_START)) && (vpos <= pos_t'(V_SYNC_END));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vid.hsync      = hsync_q;
    assign vid.vsync      = vsync_q;
    assign vid.hpos       = hpos;
    assign vid.vpos       = vpos;
    assign vid.display_on = (hpos < pos_t'(H_DISPLAY)) && (vpos < pos_t'(V_DISPLAY));

`ifdef HVSYNC_FRAME_STROBE_EN
    logic frame_q;
    logic first_q;

    // frame_q flags a wrap into (0,0); first_q covers the (0,0) cycle right after reset,
    // which no wrap edge precedes. Gating by reset keeps the strobe low while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            frame_q <= h_wrap && v_wrap;
            first_q <= 1'b0;
        end
    end

    assign vid.frame_start = (frame_q || first_q) && !reset;
`endif

endmodule

// File: tb/tb_hvsync_timing_gen.sv
module tb_hvsync_timing_gen;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    hvsync_timing_gen_if vid_if ();

    hvsync_timing_gen dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vid_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Release reset on a falling edge so the first rising edge is edge 1.
    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        release_reset();
        repeat (100) @(posedge clk);
        #1;
        chk("pre_reset_hpos", int'(vid_if.hpos), 100);
        #1;
        reset = 1'b1;   // mid-cycle, no clock edge in between
        #1;
        chk("reset_hpos", int'(vid_if.hpos), 0);
        chk("reset_vpos", int'(vid_if.vpos), 0);
        chk("reset_hsync", int'(vid_if.hsync), 0);
        chk("reset_vsync", int'(vid_if.vsync), 0);
        chk("reset_display_on", int'(vid_if.display_on), 1);
    endtask

    task automatic test_line();
        int hs_cnt, rise_h, fall_h, hs_err;
        logic prev_hs;
        hs_cnt = 0; rise_h = -1; fall_h = -1; hs_err = 0;
        release_reset();
        prev_hs = vid_if.hsync;
        for (int k = 1; k <= 309; k++) begin
            @(posedge clk);
            #1;
            if (k == 308) begin
                chk("edge308_hpos", int'(vid_if.hpos), 308);
                chk("edge308_vpos", int'(vid_if.vpos), 0);
            end
            if (k == 309) begin
                chk("edge309_hpos", int'(vid_if.hpos), 0);
                chk("edge309_vpos", int'(vid_if.vpos), 1);
            end
            if (vid_if.hsync !== ((k - 1) >= 263 && (k - 1) <= 285)) hs_err++;
            if (vid_if.hsync === 1'b1) hs_cnt++;
            if (!prev_hs && vid_if.hsync === 1'b1) rise_h = int'(vid_if.hpos);
            if (prev_hs && vid_if.hsync === 1'b0) fall_h = int'(vid_if.hpos);
            prev_hs = vid_if.hsync;
        end
        chk("line0_hsync_width", hs_cnt, 23);
        chk("line0_hsync_rise_hpos", rise_h, 264);
        chk("line0_hsync_fall_hpos", fall_h, 287);
        chk("line0_hsync_mismatches", hs_err, 0);
    endtask

    task automatic test_frame();
        int hm, vm, ph, pv, trk_err, vis, hs_cnt, vs_cnt;
        int vs_rise_h, vs_rise_v, vs_fall_h, vs_fall_v, v_before_wrap;
        logic prev_vs;
        int fs_cnt, fs_bad;
        reset = 1'b1;
        @(posedge clk);
        release_reset();
        hm = 0; vm = 0; trk_err = 0; vis = 0; hs_cnt = 0; vs_cnt = 0;
        vs_rise_h = -1; vs_rise_v = -1; vs_fall_h = -1; vs_fall_v = -1; v_before_wrap = -1;
        fs_cnt = 0; fs_bad = 0;
        prev_vs = vid_if.vsync;
`ifdef HVSYNC_FRAME_STROBE_EN
        #1;
        if (vid_if.frame_start === 1'b1) fs_cnt++;
`endif
        for (int k = 1; k <= 309 * 262; k++) begin
            @(posedge clk);
            #1;
            ph = hm; pv = vm;
            if (hm == 308) begin
                hm = 0;
                vm = (vm == 261) ? 0 : vm + 1;
            end else begin
                hm = hm + 1;
            end
            if (int'(vid_if.hpos) != hm || int'(vid_if.vpos) != vm) trk_err++;
            if (vid_if.hsync !== (ph >= 263 && ph <= 285)) trk_err++;
            if (vid_if.vsync !== (pv >= 254 && pv <= 256)) trk_err++;
            if (vid_if.display_on !== (hm < 256 && vm < 240)) trk_err++;
            if (vid_if.display_on === 1'b1) vis++;
            if (vid_if.hsync === 1'b1) hs_cnt++;
            if (vid_if.vsync === 1'b1) vs_cnt++;
            if (!prev_vs && vid_if.vsync === 1'b1) begin
                vs_rise_h = int'(vid_if.hpos); vs_rise_v = int'(vid_if.vpos);
            end
            if (prev_vs && vid_if.vsync === 1'b0) begin
                vs_fall_h = int'(vid_if.hpos); vs_fall_v = int'(vid_if.vpos);
            end
            prev_vs = vid_if.vsync;
            if (hm == 255 && vm == 239) chk("disp_255_239", int'(vid_if.display_on), 1);
            if (hm == 256 && vm == 239) chk("disp_256_239", int'(vid_if.display_on), 0);
            if (hm == 0 && vm == 240) chk("disp_0_240", int'(vid_if.display_on), 0);
            if (k == 309 * 262 - 1) v_before_wrap = int'(vid_if.vpos);
`ifdef HVSYNC_FRAME_STROBE_EN
            if (vid_if.frame_start === 1'b1) begin
                fs_cnt++;
                if (vid_if.hpos != 0 || vid_if.vpos != 0) fs_bad++;
            end
`endif
        end
        chk("frame_tracking_mismatches", trk_err, 0);
        chk("frame_vpos_before_wrap", v_before_wrap, 261);
        chk("frame_wrap_hpos", int'(vid_if.hpos), 0);
        chk("frame_wrap_vpos", int'(vid_if.vpos), 0);
        chk("frame_visible_cycles", vis, 61440);
        chk("frame_hsync_cycles", hs_cnt, 23 * 262);
        chk("frame_vsync_cycles", vs_cnt, 3 * 309);
        chk("vsync_rise_vpos", vs_rise_v, 254);
        chk("vsync_rise_hpos", vs_rise_h, 1);
        chk("vsync_fall_vpos", vs_fall_v, 257);
        chk("vsync_fall_hpos", vs_fall_h, 1);
`ifdef HVSYNC_FRAME_STROBE_EN
        // One pulse right after reset, one on the wrap back to (0,0).
        chk("frame_start_pulses", fs_cnt, 2);
        chk("frame_start_misplaced", fs_bad, 0);
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        test_reset();
        test_line();
        test_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
